// File: rtl/tnn_pool_pkg.sv
// rtl/tnn_pool_pkg.sv - shared pooling/unpooling defaults, state enum and feature type
package tnn_pool_pkg;

    localparam int FEATURE_WIDTH_DEF = 32;
    localparam int WINDOW_DEF        = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } unpool_state_e;

    typedef logic signed [FEATURE_WIDTH_DEF-1:0] feature_t;

endpackage

// File: rtl/unpool_beat_counter.sv
// rtl/unpool_beat_counter.sv - window position counter with last-beat detect
module unpool_beat_counter #(
    parameter int WINDOW    = 4,
    parameter int IDX_WIDTH = $clog2(WINDOW)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic                 inc_i,
    output logic [IDX_WIDTH-1:0] pos_o,
    output logic                 last_o
);

    localparam logic [IDX_WIDTH-1:0] LAST_POS = IDX_WIDTH'(WINDOW - 1);

    logic [IDX_WIDTH-1:0] pos_q, pos_d;

    // Load (new burst) and clear (back to idle) both restart at position 0.
    always_comb begin
        pos_d = pos_q;
        if (load_i || clear_i) begin
            pos_d = '0;
        end else if (inc_i) begin
            pos_d = pos_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o  = pos_q;
    assign last_o = (pos_q == LAST_POS);

endmodule

// File: rtl/max_unpool_unit.sv
// rtl/max_unpool_unit.sv - streaming max-unpooling; UNPOOL_IDX_CHECK_EN enables sticky index-range error
module max_unpool_unit
    import tnn_pool_pkg::*;
#(
    parameter int FEATURE_WIDTH = FEATURE_WIDTH_DEF,
    parameter int WINDOW        = WINDOW_DEF,
    parameter int IDX_WIDTH     = $clog2(WINDOW)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [FEATURE_WIDTH-1:0] in_data,
    input  logic        [IDX_WIDTH-1:0]     in_idx,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [FEATURE_WIDTH-1:0] out_data,
    output logic        [IDX_WIDTH-1:0]     out_pos,
    output logic                            out_last,
    output logic                            err
);

    unpool_state_e                   state_q, state_d;
    logic signed [FEATURE_WIDTH-1:0] val_q, val_d;
    logic        [IDX_WIDTH-1:0]     idx_q, idx_d;
    logic        [IDX_WIDTH-1:0]     cnt_pos;
    logic                            cnt_last;
    logic                            accept;
    logic                            fire;

    assign out_valid = (state_q == EMIT);
    assign fire      = out_valid && out_ready;
    assign in_ready  = (state_q == IDLE) || (fire && cnt_last);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (in_valid) state_d = EMIT;
            EMIT: if (fire && cnt_last) state_d = in_valid ? EMIT : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            val_d = in_data;
            idx_d = in_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            val_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
        end
    end

    unpool_beat_counter #(
        .WINDOW    (WINDOW),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_beat_counter (
        .clk     (clk),
        .rst     (rst),
        .clear_i (fire && cnt_last && !accept),
        .load_i  (accept),
        .inc_i   (fire && !cnt_last),
        .pos_o   (cnt_pos),
        .last_o  (cnt_last)
    );

    // An out-of-range index never matches a position, so its burst is all zeros.
    assign out_pos  = cnt_pos;
    assign out_last = out_valid && cnt_last;
    assign out_data = (out_valid && (cnt_pos == idx_q)) ? val_q : '0;

`ifdef UNPOOL_IDX_CHECK_EN
    localparam logic [IDX_WIDTH:0] WIN_EXT = WINDOW[IDX_WIDTH:0];

    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (accept && ({1'b0, in_idx} >= WIN_EXT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_max_unpool_unit.sv
// tb/tb_max_unpool_unit.sv - bench for max_unpool_unit (WINDOW=4 and WINDOW=3 side by side)
module tb_max_unpool_unit;

    typedef struct {
        logic signed [31:0] data;
        logic        [1:0]  pos;
        logic               last;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [31:0] in_data;
    logic        [1:0]  in_idx;
    logic               out_ready;

    logic               ir4, ov4, ol4, er4;
    logic signed [31:0] od4;
    logic        [1:0]  op4;
    logic               ir3, ov3, ol3, er3;
    logic signed [31:0] od3;
    logic        [1:0]  op3;

    int checks = 0;
    int errors = 0;

    beat_t q4[$];
    beat_t q3[$];
    logic  err4_m, err3_m;

    always #5 clk = ~clk;

    max_unpool_unit #(.FEATURE_WIDTH(32), .WINDOW(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
        .in_idx(in_idx), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
        .out_pos(op4), .out_last(ol4), .err(er4)
    );

    max_unpool_unit #(.FEATURE_WIDTH(32), .WINDOW(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
        .in_idx(in_idx), .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
        .out_pos(op3), .out_last(ol3), .err(er3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_unit(input string nm, input bit busy, input beat_t hd,
                              input logic ov, input logic ir, input logic signed [31:0] od,
                              input logic [1:0] op, input logic ol, input logic oe,
                              input logic errm);
        chk({nm, " out_valid"}, 32'(ov), 32'(busy));
        chk({nm, " in_ready"}, 32'(ir), 32'(!busy || (out_ready && hd.last)));
        chk({nm, " out_data"}, od, busy ? hd.data : 32'sd0);
        chk({nm, " out_pos"}, 32'(op), busy ? 32'(hd.pos) : 32'd0);
        chk({nm, " out_last"}, 32'(ol), busy ? 32'(hd.last) : 32'd0);
        chk({nm, " err"}, 32'(oe), 32'(errm));
    endtask

    // One cycle: drive inputs after the falling edge, check outputs, then advance the model on the rising edge.
    task automatic step(input bit r, input bit v, input logic signed [31:0] d,
                        input logic [1:0] idx, input bit ordy, input bit do_chk);
        beat_t nb;
        bit    b4, b3, rdy4, rdy3;
        nb = '{data: 32'sd0, pos: 2'd0, last: 1'b0};
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; in_idx = idx; out_ready = ordy;
        #1;
        b4 = (q4.size() > 0);
        b3 = (q3.size() > 0);
        rdy4 = !b4 || (ordy && q4[0].last);
        rdy3 = !b3 || (ordy && q3[0].last);
        if (do_chk) begin
            check_unit("w4", b4, b4 ? q4[0] : nb, ov4, ir4, od4, op4, ol4, er4, err4_m);
            check_unit("w3", b3, b3 ? q3[0] : nb, ov3, ir3, od3, op3, ol3, er3, err3_m);
        end
        @(posedge clk);
        if (r) begin
            q4.delete(); q3.delete();
            err4_m = 1'b0; err3_m = 1'b0;
        end else begin
            if (b4 && ordy) void'(q4.pop_front());
            if (b3 && ordy) void'(q3.pop_front());
            if (v && rdy4) begin
                for (int p = 0; p < 4; p++)
                    q4.push_back('{data: (p == int'(idx)) ? d : 32'sd0, pos: 2'(p), last: (p == 3)});
            end
            if (v && rdy3) begin
                for (int p = 0; p < 3; p++)
                    q3.push_back('{data: (p == int'(idx)) ? d : 32'sd0, pos: 2'(p), last: (p == 2)});
`ifdef UNPOOL_IDX_CHECK_EN
                if (int'(idx) >= 3) err3_m = 1'b1;
`endif
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_idx = '0; out_ready = 1'b0;
        err4_m = 1'b0; err3_m = 1'b0;

        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);

        step(0, 1, 25, 2, 1, 1);
        repeat (5) step(0, 0, 0, 0, 1, 1);

        step(0, 1, -7, 0, 1, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, (i % 2) == 1, 1);

        // Second input held valid through the first burst; accepted only on its last beat.
        step(0, 1, 5, 3, 1, 1);
        repeat (4) step(0, 1, 9, 1, 1, 1);
        repeat (5) step(0, 0, 0, 0, 1, 1);

        step(0, 1, 100, 2, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        step(1, 1, 55, 2, 1, 1);
        repeat (4) step(0, 0, 0, 0, 1, 1);

        step(0, 1, 77, 3, 1, 1);
        repeat (4) step(0, 0, 0, 0, 1, 1);
        step(0, 1, -3, 1, 1, 1);
        repeat (4) step(0, 0, 0, 0, 1, 1);

        for (int i = 0; i < 400; i++)
            step(0, $urandom_range(0, 2) != 0, $signed($urandom), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, 1);

        step(1, 0, 0, 0, 1, 1);
        repeat (2) step(0, 0, 0, 0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
